// File: rtl/turn_sequencer.sv
// Game-phase controller: card pick, timed reveal, compare against the tile ahead,
// chicken advance on a match, and the hand-off to next_turn on a miss.
module turn_sequencer #(
    parameter int REVEAL_CYCLES = 50_000_000,
    parameter int BOARD_LEN     = 24,
    parameter int WIN_LAPS      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  N,
    input  logic        card_valid,
    input  logic [3:0]  card_sel,
    input  logic [3:0]  tile_ahead,
    input  logic [1:0]  next_turn_result,
    output logic [2:0]  Q,
    output logic        statecombo_next_turn,
    output logic [1:0]  T,
    output logic        reveal_on,
    output logic        flip_back,
    output logic [19:0] pos_flat,
    output logic        game_over,
    output logic [1:0]  winner
);
    localparam int CW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    localparam logic [4:0] LAST_TILE = 5'(BOARD_LEN - 1);
    localparam logic [1:0] WIN_LAP  = 2'(WIN_LAPS);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        WAIT_CARD = 3'b001,
        REVEAL    = 3'b010,
        COMPARE   = 3'b011,
        MISS      = 3'b100,
        NEXT_TURN = 3'b101,
        LOAD_TURN = 3'b110,
        GAMEOVER  = 3'b111
    } state_t;

    state_t          state;
    logic [3:0]      card;
    logic [CW-1:0]   cnt;
    logic [4:0]      pos [4];
    logic [1:0]      lap [4];
    logic [2:0]      players;

    assign Q        = state;
    assign pos_flat = {pos[3], pos[2], pos[1], pos[0]};
    // N is decoded live; only the LOAD_TURN range check looks at it
    assign players  = (N == 2'b00) ? 3'd2 : (N == 2'b01) ? 3'd3 : 3'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            T                    <= '0;
            card                 <= '0;
            cnt                  <= '0;
            winner               <= '0;
            statecombo_next_turn <= 1'b0;
            reveal_on            <= 1'b0;
            flip_back            <= 1'b0;
            game_over            <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pos[i] <= '0;
                lap[i] <= '0;
            end
        end else begin
            flip_back            <= 1'b0;
            statecombo_next_turn <= 1'b0;
            case (state)
                IDLE, GAMEOVER: begin
                    if (start) begin
                        for (int i = 0; i < 4; i++) begin
                            pos[i] <= '0;
                            lap[i] <= '0;
                        end
                        winner    <= '0;
                        T         <= '0;
                        game_over <= 1'b0;
                        state     <= WAIT_CARD;
                    end
                end
                WAIT_CARD: begin
                    if (card_valid) begin
                        card      <= card_sel;
                        cnt       <= CW'(REVEAL_CYCLES - 1);
                        reveal_on <= 1'b1;
                        state     <= REVEAL;
                    end
                end
                REVEAL: begin
                    if (cnt == '0) begin
                        reveal_on <= 1'b0;
                        state     <= COMPARE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                COMPARE: begin
                    if (card == tile_ahead) begin
                        if (pos[T] == LAST_TILE) begin
                            pos[T] <= '0;
                            lap[T] <= lap[T] + 2'd1;
                            if (lap[T] + 2'd1 == WIN_LAP) begin
                                winner    <= T;
                                game_over <= 1'b1;
                                state     <= GAMEOVER;
                            end else begin
                                state <= WAIT_CARD;
                            end
                        end else begin
                            pos[T] <= pos[T] + 5'd1;
                            state  <= WAIT_CARD;
                        end
                    end else begin
                        flip_back <= 1'b1;
                        state     <= MISS;
                    end
                end
                MISS: begin
                    statecombo_next_turn <= 1'b1;
                    state                <= NEXT_TURN;
                end
                NEXT_TURN: state <= LOAD_TURN;
                LOAD_TURN: begin
                    T     <= ({1'b0, next_turn_result} >= players) ? 2'd0 : next_turn_result;
                    state <= WAIT_CARD;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Top-level game-phase controller for the Chicken Cha Cha Cha board.
- Accepts a player's card pick, holds the reveal, compares the pick against the tile ahead, and advances that player's chicken on a match.
- On a miss it runs the turn hand-off. It drives the 3-bit phase code Q and the statecombo_next_turn strobe into next_turn, then latches next_turn's result as the new current player.
- Sits directly upstream of next_turn; also feeds the board/display logic.

Parameters:
- REVEAL_CYCLES, 50_000_000: cycles a flipped card stays shown before compare (≥1).
- BOARD_LEN, 24: number of track tiles (2..32).
- WIN_LAPS, 1: laps needed to win (1..3).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a new game
- N  in  2  player-count code: 00 = 2, 01 = 3, 10 = 4, 11 = 4
- card_valid  in  1  one-cycle pulse; card_sel is valid
- card_sel  in  4  animal id on the picked card
- tile_ahead  in  4  animal id of the tile in front of the current player
- next_turn_result  in  2  next player index computed by next_turn
- Q  out  3  phase code
- statecombo_next_turn  out  1  high exactly while Q = 101
- T  out  2  current player index
- reveal_on  out  1  card face shown (Q = 010)
- flip_back  out  1  one-cycle pulse in MISS
- pos_flat  out  20  positions, 5 bits per player; player 0 in bits [4:0]
- game_over  out  1  high in GAMEOVER
- winner  out  2  index of the winning player; valid when game_over = 1

Behaviour:
- Reset (async, any state) clears everything:
  - Q = 000; T = 0; all positions, laps, counter and winner = 0.
  - statecombo_next_turn, reveal_on, flip_back and game_over = 0.
- All state updates occur on the posedge of clk. Q is the state register itself.
- 000 IDLE: start → clear positions, laps and winner; set T = 0; go to 001.
- 001 WAIT_CARD:
  - card_valid → latch card_sel; load counter = REVEAL_CYCLES-1; go to 010.
  - card_valid seen in any other state is ignored.
- 010 REVEAL: reveal_on = 1; decrement the counter; go to 011 in the cycle after the counter reaches 0. Dwell is exactly REVEAL_CYCLES cycles.
- 011 COMPARE (1 cycle): latched card == tile_ahead is a match.
  - On a match, pos[T] += 1. Going from BOARD_LEN-1 wraps to 0 and increments lap[T].
  - If lap[T] reaches WIN_LAPS: winner = T, go to 111. Otherwise go to 001, and the same player keeps the turn.
  - On a mismatch: go to 100.
- 100 MISS (1 cycle): flip_back = 1; go to 101.
- 101 NEXT_TURN (1 cycle): statecombo_next_turn = 1; go to 110.
- 110 LOAD_TURN (1 cycle): T = next_turn_result; go to 001.
  - If next_turn_result ≥ player count, T = 0 instead.
- 111 GAMEOVER: game_over = 1; positions, laps and winner hold; start → same action as in IDLE.
- start is ignored in states 001–110.
- Miss-path latency, COMPARE to new T visible: 3 cycles (100, 101, 110).
- pos_flat entries for non-playing players stay 0 and are never moved.
- N is sampled continuously. A change mid-game takes effect at the next LOAD_TURN range check only.

Test Plan:
- Reset then start with N = 00 → Q: 000 → 001, T = 0, pos_flat = 0. Async rst asserted mid-REVEAL → Q = 000 and reveal_on = 0 immediately, without waiting for a clock edge.
- REVEAL_CYCLES = 4, card_valid with card_sel = 3, tile_ahead = 3 → reveal_on high for exactly 4 cycles; then pos[0] = 1, Q = 001, T unchanged.
- Mismatch (card_sel = 2, tile_ahead = 5), next_turn_result = 01:
  - Q sequence is 011 → 100 → 101 → 110 → 001.
  - flip_back pulses 1 cycle and statecombo_next_turn pulses 1 cycle in 101.
  - T = 1 once Q reaches 001.
- N = 00, next_turn_result = 10 at LOAD_TURN → T = 0 (out-of-range clamp).
- BOARD_LEN = 4, WIN_LAPS = 1, four consecutive matches by player 0 → pos[0] sequence 1, 2, 3, 0; Q = 111, game_over = 1, winner = 0. card_valid then ignored; start → Q = 001 with positions cleared.
- card_valid pulsed during 010/100/101 and start pulsed during 001 → no state change and no counter reload.
